// File: rtl/mux_lut_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_lut_pkg
// Description : Shared types and constants for the mux_lut_gate cell:
//               load-FSM state encoding, truth-table width and the
//               standard 2-input function tables.
//               Table index is {a, b}; result bit = tt[{a, b}].
// Revision    : 1.0 - initial release
// ============================================================================
package mux_lut_pkg;

    localparam int TT_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    localparam logic [TT_W-1:0] TT_NAND  = 4'b0111;
    localparam logic [TT_W-1:0] TT_NOR   = 4'b0001;
    localparam logic [TT_W-1:0] TT_AND   = 4'b1000;
    localparam logic [TT_W-1:0] TT_XOR   = 4'b0110;
    localparam logic [TT_W-1:0] TT_RESET = TT_NAND;

endpackage
`default_nettype wire

// File: rtl/mux4_bit.sv
`default_nettype none
// ============================================================================
// Module      : mux4_bit
// Description : Single-bit 4:1 multiplexer, the per-lane lookup element.
// Ports       : data - 4 data inputs (the truth table)
//               sel  - select, {a, b} of the lane
//               y    - selected bit, data[sel]
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_bit
    import mux_lut_pkg::*;
(
    input  logic [TT_W-1:0] data,
    input  logic [1:0]      sel,
    output logic            y
);

    assign y = data[sel];

endmodule
`default_nettype wire

// File: rtl/mux_lut_gate.sv
`default_nettype none
// ============================================================================
// Module      : mux_lut_gate
// Description : Registered universal 2-input gate array. Every lane i
//               produces tt_active[{a[i], b[i]}]. The truth table is
//               loaded serially (MSB first) through the cfg_* port while
//               the data path is stalled, then swapped in atomically.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid/in_ready   - operand handshake (ready only in IDLE)
//               a, b                - operands, WIDTH lanes
//               out_valid/out_data  - registered result, 1-cycle valid pulse
//               cfg_start           - open a table load
//               cfg_valid/cfg_bit   - serial table bits, tt[3] first
//               cfg_done            - pulse when the new table is active
//               tt_active           - currently active table
// Revision    : 1.0 - initial release
// ============================================================================
module mux_lut_gate
    import mux_lut_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_done,
    output logic [TT_W-1:0]  tt_active
);

    state_t            r_state;
    logic [1:0]        r_cnt;
    logic [TT_W-1:0]   r_shadow;
    logic [TT_W-1:0]   r_tt;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_valid;
    logic              r_cfg_done;

    logic              w_accept;
    logic [TT_W-1:0]   w_shadow_next;
    logic [WIDTH-1:0]  w_lut;

    // Ready is a pure state decode, so there is no path from any input.
    assign in_ready      = (r_state == IDLE);
    assign w_accept      = in_valid & in_ready;
    assign w_shadow_next = {r_shadow[TT_W-2:0], cfg_bit};

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            mux4_bit u_mux (
                .data (r_tt),
                .sel  ({a[gi], b[gi]}),
                .y    (w_lut[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 2'd0;
            r_shadow    <= '0;
            r_tt        <= TT_RESET;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_cfg_done  <= 1'b0;
        end else begin
            r_cfg_done  <= 1'b0;
            r_out_valid <= w_accept;
            // Operands taken on the same edge as cfg_start still see the
            // old table, because r_tt only changes at the end of a load.
            if (w_accept) begin
                r_out_data <= w_lut;
            end

            case (r_state)
                IDLE: begin
                    if (cfg_start) begin
                        r_state  <= LOAD;
                        r_cnt    <= 2'd0;
                        r_shadow <= '0;
                    end
                end
                LOAD: begin
                    if (cfg_valid) begin
                        r_shadow <= w_shadow_next;
                        r_cnt    <= r_cnt + 2'd1;
                        // The 4th bit goes straight into the active table
                        // so the swap happens on the same edge it arrives.
                        if (r_cnt == 2'd3) begin
                            r_tt       <= w_shadow_next;
                            r_cfg_done <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign cfg_done  = r_cfg_done;
    assign tt_active = r_tt;

endmodule
`default_nettype wire
